// File: rtl/conv_window_stream.sv
// rtl/conv_window_stream.sv - streaming KxK sliding-window generator with line memories
module conv_window_stream #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 224,
    parameter int IMG_H  = 224,
    parameter int K      = 3,
    parameter int STRIDE = 1,
    localparam int OUT_H = (IMG_H - K) / STRIDE + 1,
    localparam int OUT_W = (IMG_W - K) / STRIDE + 1,
    localparam int OR_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int OC_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  frame_abort,
    output logic [K*K*DATA_W-1:0] win_data,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [OR_W-1:0]       win_row,
    output logic [OC_W-1:0]       win_col,
    output logic                  frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int WB = K * K * DATA_W;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
    localparam logic [CW-1:0] COL_PRE   = CW'(K - 2);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
    localparam logic [RW-1:0] ROW_PRE   = RW'(K - 2);
    localparam logic [SW-1:0] PH_LAST   = SW'(STRIDE - 1);

    logic [DATA_W-1:0] line_q [K-1][IMG_W];
    logic [DATA_W-1:0] win_q  [K][K];
    logic [DATA_W-1:0] win_d  [K][K];
    logic [WB-1:0]     win_flat;

    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [SW-1:0]   sc_q, sc_d, sr_q, sr_d;
    logic [OR_W-1:0] orow_q, orow_d, out_row_q, out_row_d;
    logic [OC_W-1:0] ocol_q, ocol_d, out_col_q, out_col_d;
    logic            out_valid_q, out_valid_d;
    logic [WB-1:0]   out_data_q, out_data_d;
    logic            done_q, done_d;

    logic fire, emit, col_end, row_end;

    assign in_ready = !out_valid_q || win_ready;
    assign fire     = in_valid && in_ready && !frame_abort;
    assign col_end  = (col_q == COL_LAST);
    assign row_end  = (row_q == ROW_LAST);
    assign emit     = fire && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST)
                      && (sr_q == '0) && (sc_q == '0);

    // Shift the window left; the new right column is the stored lines above the incoming pixel.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            win_d[r][K-1] = line_q[K-2-r][col_q];
        end
        win_d[K-1][K-1] = in_data;
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_flat[(K*K-1-(r*K+c))*DATA_W +: DATA_W] = win_d[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            line_q[0][col_q] <= in_data;
            for (int j = 1; j < K - 1; j++) begin
                line_q[j][col_q] <= line_q[j-1][col_q];
            end
            win_q <= win_d;
        end
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        sc_d        = sc_q;
        sr_d        = sr_q;
        orow_d      = orow_q;
        ocol_d      = ocol_q;
        out_valid_d = out_valid_q && !win_ready;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        done_d      = 1'b0;
        if (frame_abort) begin
            col_d       = '0;
            row_d       = '0;
            sc_d        = '0;
            sr_d        = '0;
            orow_d      = '0;
            ocol_d      = '0;
            out_valid_d = 1'b0;
        end else if (fire) begin
            if (emit) begin
                out_valid_d = 1'b1;
                out_data_d  = win_flat;
                out_row_d   = orow_q;
                out_col_d   = ocol_q;
                ocol_d      = ocol_q + 1'b1;
            end
            // Phase counters describe the pixel about to arrive; zero phase marks a window position.
            if (col_end) begin
                col_d  = '0;
                sc_d   = '0;
                ocol_d = '0;
                if (row_end) begin
                    row_d  = '0;
                    sr_d   = '0;
                    orow_d = '0;
                    done_d = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                    sr_d  = (row_q == ROW_PRE || sr_q == PH_LAST) ? '0 : sr_q + 1'b1;
                    if (row_q >= ROW_FIRST && sr_q == '0) begin
                        orow_d = orow_q + 1'b1;
                    end
                end
            end else begin
                col_d = col_q + 1'b1;
                sc_d  = (col_q == COL_PRE || sc_q == PH_LAST) ? '0 : sc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            col_q       <= '0;
            row_q       <= '0;
            sc_q        <= '0;
            sr_q        <= '0;
            orow_q      <= '0;
            ocol_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            sc_q        <= sc_d;
            sr_q        <= sr_d;
            orow_q      <= orow_d;
            ocol_q      <= ocol_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            done_q      <= done_d;
        end
    end

    assign win_data   = out_data_q;
    assign win_valid  = out_valid_q;
    assign win_row    = out_row_q;
    assign win_col    = out_col_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_conv_window_stream.sv
// tb/tb_conv_window_stream.sv - scoreboard bench for conv_window_stream, 5x5 image, K=3, strides 1 and 2
module tb_conv_window_stream;

    localparam int W  = 5;
    localparam int H  = 5;
    localparam int K  = 3;
    localparam int DW = 16;
    localparam int WB = K * K * DW;

    typedef struct {
        logic [WB-1:0] data;
        int            row;
        int            col;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_a;
    logic [DW-1:0] drv_data;
    logic          drv_valid;
    int            sel;
    logic          frame_abort;
    logic          win_ready = 1'b1;
    logic          in_valid1, in_valid2, in_ready1, in_ready2, cur_in_ready;
    logic [WB-1:0] win_data1, win_data2;
    logic          win_valid1, win_valid2;
    logic [1:0]    win_row1, win_col1;
    logic [0:0]    win_row2, win_col2;
    logic          frame_done1, frame_done2;

    int   total = 0;
    int   bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   frames0 = 0, frames1 = 0, done0 = 0, done1 = 0;
    int   rdy_mode = 0;
    bit   gaps = 0;
    bit   bp_seen = 0;
    logic [WB-1:0] first_win, bp_win;

    assign in_valid1    = drv_valid && (sel == 0);
    assign in_valid2    = drv_valid && (sel == 1);
    assign cur_in_ready = (sel == 0) ? in_ready1 : in_ready2;

    always #5 clk = ~clk;

    conv_window_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(K), .STRIDE(1)) u_s1 (
        .clk(clk), .rst_a(rst_a), .in_data(drv_data), .in_valid(in_valid1), .in_ready(in_ready1),
        .frame_abort(frame_abort), .win_data(win_data1), .win_valid(win_valid1),
        .win_ready(win_ready), .win_row(win_row1), .win_col(win_col1), .frame_done(frame_done1)
    );

    conv_window_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .K(K), .STRIDE(2)) u_s2 (
        .clk(clk), .rst_a(rst_a), .in_data(drv_data), .in_valid(in_valid2), .in_ready(in_ready2),
        .frame_abort(frame_abort), .win_data(win_data2), .win_valid(win_valid2),
        .win_ready(win_ready), .win_row(win_row2), .win_col(win_col2), .frame_done(frame_done2)
    );

    task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Window (orow,ocol) covers image rows orow*s..+K-1 and columns ocol*s..+K-1.
    function automatic logic [WB-1:0] model_win(input int base, input int s, input int orow, input int ocol);
        logic [WB-1:0] p;
        p = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                p[(K*K-1-(r*K+c))*DW +: DW] = DW'(base + (orow*s + r)*W + ocol*s + c);
            end
        end
        return p;
    endfunction

    function automatic logic [WB-1:0] pack9(input int v[9]);
        logic [WB-1:0] p;
        p = '0;
        for (int i = 0; i < 9; i++) p[(8-i)*DW +: DW] = DW'(v[i]);
        return p;
    endfunction

    task automatic send_pixel(input logic [DW-1:0] v);
        bit acc;
        while (gaps && ($urandom_range(1, 0) == 1)) begin
            drv_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        drv_valid = 1'b1;
        drv_data  = v;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            acc = cur_in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                drv_valid = 1'b0;
                return;
            end
        end
        drv_valid = 1'b0;
        total++;
        bad++;
        $display("FAIL pixel_accept_timeout: got no in_ready for value %0d expected accept", v);
    endtask

    task automatic issue_frame(input int base, input int s_sel, input int npix, input bit lat_chk);
        int   s, oh, ow;
        exp_t e;
        s   = (s_sel == 0) ? 1 : 2;
        oh  = (H - K) / s + 1;
        ow  = (W - K) / s + 1;
        sel = s_sel;
        if (npix == W * H) begin
            for (int r = 0; r < oh; r++) begin
                for (int c = 0; c < ow; c++) begin
                    e.data = model_win(base, s, r, c);
                    e.row  = r;
                    e.col  = c;
                    if (s_sel == 0) q0.push_back(e);
                    else q1.push_back(e);
                end
            end
            if (s_sel == 0) frames0++;
            else frames1++;
        end
        for (int i = 0; i < npix; i++) begin
            send_pixel(DW'(base + i));
            if (lat_chk && i == 11) chk("no_window_before_px12", WB'(win_valid1), WB'(0));
            if (lat_chk && i == 12) begin
                chk("valid_after_px12", WB'(win_valid1), WB'(1));
                chk("first_window_data", win_data1, first_win);
            end
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_q_s1", WB'(q0.size()), WB'(0));
        chk("drain_q_s2", WB'(q1.size()), WB'(0));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_a && win_valid1 && win_ready) begin
                if (q0.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL s1_unexpected_window: got row %0d col %0d expected none", win_row1, win_col1);
                end else begin
                    e = q0.pop_front();
                    chk("s1_win_data", win_data1, e.data);
                    chk("s1_win_row", WB'(win_row1), WB'(e.row));
                    chk("s1_win_col", WB'(win_col1), WB'(e.col));
                end
            end
            if (!rst_a && win_valid2 && win_ready) begin
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL s2_unexpected_window: got row %0d col %0d expected none", win_row2, win_col2);
                end else begin
                    e = q1.pop_front();
                    chk("s2_win_data", win_data2, e.data);
                    chk("s2_win_row", WB'(win_row2), WB'(e.row));
                    chk("s2_win_col", WB'(win_col2), WB'(e.col));
                end
            end
            if (!rst_a && frame_done1) done0++;
            if (!rst_a && frame_done2) done1++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 2 && !bp_seen && win_valid1 && win_row1 == 2'd0 && win_col1 == 2'd1) begin
                bp_seen   = 1'b1;
                win_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("bp_data_hold", win_data1, bp_win);
                    chk("bp_in_ready_low", WB'(in_ready1), WB'(0));
                    chk("bp_valid_hold", WB'(win_valid1), WB'(1));
                    @(posedge clk);
                    #1;
                end
                win_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                win_ready = 1'($urandom_range(1, 0));
            end else begin
                win_ready = 1'b1;
            end
        end
    end

    initial begin
        int v[9];
        rst_a       = 1'b1;
        drv_valid   = 1'b0;
        drv_data    = '0;
        sel         = 0;
        frame_abort = 1'b0;
        v = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        first_win = pack9(v);
        v = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
        bp_win = pack9(v);

        #12;
        chk("rst_in_ready", WB'(in_ready1), WB'(1));
        chk("rst_win_valid", WB'(win_valid1), WB'(0));
        chk("rst_win_data", win_data1, WB'(0));
        chk("rst_win_row", WB'(win_row1), WB'(0));
        chk("rst_win_col", WB'(win_col1), WB'(0));
        chk("rst_frame_done", WB'(frame_done1), WB'(0));
        chk("rst_s2_valid", WB'(win_valid2), WB'(0));
        @(negedge clk);
        rst_a = 1'b0;
        @(posedge clk);
        #1;

        issue_frame(0, 0, W*H, 1'b1);
        issue_frame(0, 1, W*H, 1'b0);
        drain();

        rdy_mode = 2;
        issue_frame(0, 0, W*H, 1'b0);
        drain();
        chk("bp_observed", WB'(bp_seen), WB'(1));

        rdy_mode = 1;
        gaps = 1'b1;
        issue_frame(0, 0, W*H, 1'b0);
        issue_frame(100, 0, W*H, 1'b0);
        gaps = 1'b0;
        issue_frame(200, 1, W*H, 1'b0);
        issue_frame(300, 1, W*H, 1'b0);
        rdy_mode = 0;
        drain();

        issue_frame(0, 0, 9, 1'b0);
        rst_a = 1'b1;
        #1;
        chk("midrst_win_valid", WB'(win_valid1), WB'(0));
        chk("midrst_win_data", win_data1, WB'(0));
        chk("midrst_win_row", WB'(win_row1), WB'(0));
        chk("midrst_win_col", WB'(win_col1), WB'(0));
        chk("midrst_in_ready", WB'(in_ready1), WB'(1));
        @(negedge clk);
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        issue_frame(0, 0, W*H, 1'b1);
        drain();

        issue_frame(0, 0, 9, 1'b0);
        sel         = 0;
        frame_abort = 1'b1;
        drv_valid   = 1'b1;
        drv_data    = 16'd999;
        @(posedge clk);
        #1;
        frame_abort = 1'b0;
        drv_valid   = 1'b0;
        chk("abort_win_valid", WB'(win_valid1), WB'(0));
        chk("abort_in_ready", WB'(in_ready1), WB'(1));
        issue_frame(0, 0, W*H, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        #1;
        chk("frame_done_count_s1", WB'(done0), WB'(frames0));
        chk("frame_done_count_s2", WB'(done1), WB'(frames1));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
